vdp_datapath: RTL and testbench

Fixed-point arithmetic datapath for the Van der Pol oscillator, driven cycle-by-cycle by the step controller. It holds the state variables x and y and evaluates one forward-Euler step (x' = y, y' = mu(1-x^2)y - x) across controller states S1..S4. It commits the new (x, y) on the controller's done cycle. Each committed sample is pushed into a small output FIFO with a valid/ready handshake for downstream consumers.

---
 rtl/vdp_datapath.sv | 198 +++++++++++++++++++
 tb/tb_vdp_datapath.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_datapath.sv
// Fixed-point forward-Euler datapath for the Van der Pol oscillator, sequenced by an
// external step controller, with a small valid/ready FIFO holding committed (x, y) samples.
module vdp_datapath #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int H     = 256,
  parameter int HMU   = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] x_init,
  input  logic [WIDTH-1:0] y_init,
  input  logic [2:0]       state,
  input  logic [1:0]       mux_sel,
  input  logic             alu_sub,
  input  logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             sat_flag,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] H_Q   = WIDTH'(H);
  localparam logic signed [WIDTH-1:0] HMU_Q = WIDTH'(HMU);

  // Both helpers return {saturated, value}.
  function automatic logic [WIDTH:0] mul_sat(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shr;
    prod = a * b;
    shr  = prod >>> FRAC;
    if (&shr[2*WIDTH-1:WIDTH-1] || ~|shr[2*WIDTH-1:WIDTH-1])
      mul_sat = {1'b0, shr[WIDTH-1:0]};
    else
      mul_sat = {1'b1, shr[2*WIDTH-1] ? SAT_MIN : SAT_MAX};
  endfunction

  function automatic logic [WIDTH:0] add_sat(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b,
                                             input logic                    sub);
    logic signed [WIDTH:0] sum;
    if (sub) sum = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    else     sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (sum[WIDTH] == sum[WIDTH-1])
      add_sat = {1'b0, sum[WIDTH-1:0]};
    else
      add_sat = {1'b1, sum[WIDTH] ? SAT_MIN : SAT_MAX};
  endfunction

  logic signed [WIDTH-1:0] x, y;
  logic signed [WIDTH-1:0] t1, t2, t3, t4, t5, t6, t7, t_xn;
  logic signed [WIDTH-1:0] m0_a, m0_b, m1_a, m1_b, add_a, add_b;
  logic [WIDTH:0]          m0_r, m1_r, add_r, cy_r;
  logic                    work, op_sat, sat_any;

  logic [WIDTH-1:0] fifo_x [DEPTH];
  logic [WIDTH-1:0] fifo_y [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, pop, push;

  assign work = (state != 3'd0);

  // Two shared multipliers and one adder, operands steered by the controller's mux_sel.
  always_comb begin
    m0_a  = x;
    m0_b  = x;
    m1_a  = H_Q;
    m1_b  = y;
    add_a = x;
    add_b = t2;
    case (mux_sel)
      2'b01: begin
        m0_a = HMU_Q;
        m0_b = y;
        m1_a = H_Q;
        m1_b = x;
      end
      2'b10: begin
        m0_a  = t3;
        m0_b  = t1;
        add_a = t3;
        add_b = t4;
      end
      2'b11: begin
        add_a = t6;
        add_b = t5;
      end
      default: ;
    endcase
  end

  assign m0_r  = mul_sat(m0_a, m0_b);
  assign m1_r  = mul_sat(m1_a, m1_b);
  assign add_r = add_sat(add_a, add_b, alu_sub);
  assign cy_r  = add_sat(y, t7, 1'b0);

  // Only results that are actually written may raise the saturation flag.
  always_comb begin
    op_sat = 1'b0;
    case (mux_sel)
      2'b00:   op_sat = m0_r[WIDTH] | m1_r[WIDTH];
      2'b01:   op_sat = m0_r[WIDTH] | m1_r[WIDTH] | add_r[WIDTH];
      2'b10:   op_sat = m0_r[WIDTH] | add_r[WIDTH];
      default: op_sat = add_r[WIDTH];
    endcase
    sat_any = (work & op_sat) | (done & cy_r[WIDTH]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t1   <= '0;
      t2   <= '0;
      t3   <= '0;
      t4   <= '0;
      t5   <= '0;
      t6   <= '0;
      t7   <= '0;
      t_xn <= '0;
    end else if (work) begin
      case (mux_sel)
        2'b00: begin
          t1 <= m0_r[WIDTH-1:0];
          t2 <= m1_r[WIDTH-1:0];
        end
        2'b01: begin
          t3   <= m0_r[WIDTH-1:0];
          t4   <= m1_r[WIDTH-1:0];
          t_xn <= add_r[WIDTH-1:0];
        end
        2'b10: begin
          t5 <= m0_r[WIDTH-1:0];
          t6 <= add_r[WIDTH-1:0];
        end
        default: t7 <= add_r[WIDTH-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (done) begin
      x <= t_xn;
      y <= cy_r[WIDTH-1:0];
    end else if (load && !work) begin
      x <= x_init;
      y <= y_init;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = out_valid & out_ready;
  // A full FIFO still accepts the commit when the head leaves in the same cycle.
  assign push  = done & (~full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_x[i] <= '0;
        fifo_y[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_x[wr_ptr[AW-1:0]] <= t_xn;
        fifo_y[wr_ptr[AW-1:0]] <= cy_r[WIDTH-1:0];
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sat_flag <= sat_flag | sat_any;
      overflow <= overflow | (done & full & ~pop);
    end
  end

  assign out_valid = ~empty;
  assign out_x     = empty ? '0 : fifo_x[rd_ptr[AW-1:0]];
  assign out_y     = empty ? '0 : fifo_y[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_vdp_datapath.sv
// Bench for vdp_datapath: drives controller sequences with random loads and consumer
// stalls, checking every cycle against a whole-step Euler model with a queue for the FIFO.
module tb_vdp_datapath;
  localparam int W = 16;
  localparam int F = 12;
  localparam int HV = 256;
  localparam int HMUV = 256;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] x_init = '0;
  logic [W-1:0] y_init = '0;
  logic [2:0]   state = '0;
  logic [1:0]   mux_sel = '0;
  logic         alu_sub = 1'b0;
  logic         done = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_x, out_y;
  logic         sat_flag, overflow;

  vdp_datapath #(.WIDTH(W), .FRAC(F), .H(HV), .HMU(HMUV), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .load(load), .x_init(x_init), .y_init(y_init),
    .state(state), .mux_sel(mux_sel), .alu_sub(alu_sub), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .sat_flag(sat_flag), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int mx = 0, my = 0;
  bit msat = 1'b0, movf = 1'b0;
  int qx[$];
  int qy[$];

  function automatic int clampw(input longint v, inout bit s);
    if (v > 32767) begin s = 1'b1; return 32767; end
    if (v < -32768) begin s = 1'b1; return -32768; end
    return int'(v);
  endfunction

  function automatic int qmul(input int a, input int b, inout bit s);
    return clampw((longint'(a) * longint'(b)) >>> F, s);
  endfunction

  // One Euler step: x' = x + h*y ; y' = y + (h*mu*y - h*x - h*mu*y*x^2)
  function automatic void euler(input int x, input int y, output int xn, output int yn,
                                output bit s);
    int hy, hmuy, x2, hx, damp, dy;
    s    = 1'b0;
    x2   = qmul(x, x, s);
    hy   = qmul(HV, y, s);
    hmuy = qmul(HMUV, y, s);
    hx   = qmul(HV, x, s);
    xn   = clampw(longint'(x) + hy, s);
    damp = qmul(hmuy, x2, s);
    dy   = clampw(longint'(clampw(longint'(hmuy) - hx, s)) - damp, s);
    yn   = clampw(longint'(y) + dy, s);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin : model
    bit pop;
    bit s;
    int xn, yn;
    if (!reset) begin
      mx = 0; my = 0; msat = 1'b0; movf = 1'b0;
      qx.delete(); qy.delete();
    end else begin
      pop = (qx.size() > 0) && out_ready;
      if (pop) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
      if (done) begin
        euler(mx, my, xn, yn, s);
        mx = xn; my = yn;
        msat = msat | s;
        if (qx.size() == D) movf = 1'b1;
        else begin
          qx.push_back(xn);
          qy.push_back(yn);
        end
      end else if (load && state == 3'd0) begin
        mx = $signed(x_init);
        my = $signed(y_init);
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", longint'(out_valid), longint'(qx.size() > 0));
    chk("out_x", longint'($signed(out_x)), (qx.size() > 0) ? longint'(qx[0]) : 0);
    chk("out_y", longint'($signed(out_y)), (qy.size() > 0) ? longint'(qy[0]) : 0);
    chk("overflow", longint'(overflow), longint'(movf));
    if (state == 3'd0 && !done) chk("sat_flag", longint'(sat_flag), longint'(msat));
  end

  task automatic cyc(input int st, input int ms, input bit sub, input bit dn, input bit ld,
                     input int rdy);
    @(posedge clk);
    #1;
    state   = 3'(st);
    mux_sel = 2'(ms);
    alu_sub = sub;
    done    = dn;
    load    = ld;
    out_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy);
  endtask

  task automatic idle(input int rdy);
    cyc(0, 0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic step(input int rdy, input int rdy_done);
    cyc(1, 0, 1'b0, 1'b0, 1'b0, rdy);
    cyc(2, 1, 1'b0, 1'b0, 1'b0, rdy);
    cyc(3, 2, 1'b1, 1'b0, 1'b0, rdy);
    cyc(4, 3, 1'b1, 1'b0, 1'b0, rdy);
    cyc(0, 0, 1'b0, 1'b1, 1'b0, rdy_done);
  endtask

  task automatic do_load(input int xv, input int yv, input int rdy);
    x_init = W'(xv);
    y_init = W'(yv);
    cyc(0, 0, 1'b0, 1'b0, 1'b1, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    state = '0; mux_sel = '0; alu_sub = 1'b0; done = 1'b0; load = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ex, ey;
    bit es;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    chk("rst out_valid", longint'(out_valid), 0);
    chk("rst out_x", longint'(out_x), 0);
    chk("rst out_y", longint'(out_y), 0);
    chk("rst sat_flag", longint'(sat_flag), 0);
    chk("rst overflow", longint'(overflow), 0);

    euler(4096, 0, ex, ey, es);
    chk("model step1 x", ex, 4096);
    chk("model step1 y", ey, -256);
    chk("model step1 sat", longint'(es), 0);
    euler(4096, -256, ex, ey, es);
    chk("model step2 x", ex, 4080);
    chk("model step2 y", ey, -512);
    euler(32767, 32767, ex, ey, es);
    chk("model sat x", ex, 32767);
    chk("model sat flag", longint'(es), 1);

    // Two consecutive steps from (1.0, 0), held then popped one by one.
    do_load(4096, 0, 0);
    idle(0);
    step(0, 0);
    idle(0);
    chk("s1 out_valid", longint'(out_valid), 1);
    chk("s1 out_x", longint'($signed(out_x)), 4096);
    chk("s1 out_y", longint'($signed(out_y)), -256);
    chk("s1 sat_flag", longint'(sat_flag), 0);
    step(0, 0);
    idle(0);
    chk("s2 head x", longint'($signed(out_x)), 4096);
    idle(1);
    idle(0);
    chk("s2 out_x", longint'($signed(out_x)), 4080);
    chk("s2 out_y", longint'($signed(out_y)), -512);
    idle(1);
    idle(0);
    chk("s2 drained", longint'(out_valid), 0);

    // Saturation is sticky.
    do_reset();
    do_load(32767, 32767, 0);
    idle(0);
    step(0, 0);
    idle(0);
    chk("sat out_x", longint'($signed(out_x)), 32767);
    chk("sat flag", longint'(sat_flag), 1);
    repeat (3) idle(1);
    chk("sat sticky", longint'(sat_flag), 1);
    chk("sat drained", longint'(out_valid), 0);

    // Five steps into a four-entry FIFO with the consumer stalled.
    do_reset();
    do_load(4096, 0, 0);
    idle(0);
    step(0, 0);
    idle(0);
    chk("ovf valid after first", longint'(out_valid), 1);
    repeat (4) step(0, 0);
    idle(0);
    chk("ovf flag", longint'(overflow), 1);
    chk("ovf head x", longint'($signed(out_x)), 4096);
    chk("ovf head y", longint'($signed(out_y)), -256);
    repeat (4) idle(1);
    idle(0);
    chk("ovf drained", longint'(out_valid), 0);
    step(0, 0);
    idle(1);
    idle(0);

    // Full FIFO with a pop on the commit cycle.
    do_reset();
    do_load(4096, 0, 0);
    idle(0);
    repeat (4) step(0, 0);
    idle(0);
    chk("full no ovf", longint'(overflow), 0);
    step(0, 1);
    idle(0);
    chk("pop+push ovf", longint'(overflow), 0);
    chk("pop+push head x", longint'($signed(out_x)), 4080);
    chk("pop+push head y", longint'($signed(out_y)), -512);
    repeat (4) idle(1);
    idle(0);

    // Reset in the middle of S3 with entries queued, then a load during S2 is ignored.
    do_load(4096, 0, 0);
    idle(0);
    step(0, 0);
    step(0, 0);
    cyc(1, 0, 1'b0, 1'b0, 1'b0, 0);
    cyc(2, 1, 1'b0, 1'b0, 1'b0, 0);
    cyc(3, 2, 1'b1, 1'b0, 1'b0, 0);
    #3 reset = 1'b0;
    #1;
    chk("midrst out_valid", longint'(out_valid), 0);
    chk("midrst out_x", longint'(out_x), 0);
    chk("midrst out_y", longint'(out_y), 0);
    chk("midrst sat", longint'(sat_flag), 0);
    chk("midrst ovf", longint'(overflow), 0);
    idle(0);
    reset = 1'b1;
    x_init = W'(1000);
    y_init = W'(2000);
    cyc(1, 0, 1'b0, 1'b0, 1'b0, 0);
    cyc(2, 1, 1'b0, 1'b0, 1'b1, 0);
    cyc(3, 2, 1'b1, 1'b0, 1'b0, 0);
    cyc(4, 3, 1'b1, 1'b0, 1'b0, 0);
    cyc(0, 0, 1'b0, 1'b1, 1'b0, 0);
    idle(0);
    chk("ignored load x", longint'($signed(out_x)), 0);
    chk("ignored load y", longint'($signed(out_y)), 0);
    step(1, 1);
    idle(1);
    idle(0);

    // Randomized loads, back-to-back steps and consumer stalls.
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        do_load(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 2);
        idle(2);
      end else if (r < 4) begin
        do_load(int'($urandom_range(0, 24576)) - 12288, int'($urandom_range(0, 24576)) - 12288, 2);
        idle(2);
      end
      step(2, 2);
      if ($urandom_range(0, 1) == 1) step(2, 2);
      repeat ($urandom_range(0, 3)) idle(2);
    end
    repeat (6) idle(1);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
